// File: rtl/key_entry_sseg_if.sv
// ---------------------------------------------------------------------------
// key_entry_sseg_if
//   Bundles the key-entry / display signals of key_entry_sseg so the block
//   and its environment connect through one port.
//
//   keyin      4   hex key code from the keypad scanner (holds last key)
//   clr        1   synchronous level clear of the entry register
//   an         4   digit enables, active-low, an[0] = rightmost digit
//   seg        7   segments {g,f,e,d,c,b,a}, active-low
//   dp         1   decimal point, active-low (lit = overflow flag)
//   digits    16   entry register, digits[3:0] = newest digit
//   key_event  1   one-cycle pulse when a key is committed
//   state      2   entry FSM state (debug visibility)
//
//   Handshake: key_event is a valid-only strobe with no ready. It is high
//   for exactly one clock per committed key, digits already holds the new
//   value in that same cycle, and the consumer must sample it then; the
//   block never stalls or repeats a strobe.
//
//   master: the keypad/host side (drives keyin/clr).
//   slave : key_entry_sseg itself.
// ---------------------------------------------------------------------------
interface key_entry_sseg_if;
    logic [3:0]  keyin;
    logic        clr;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] digits;
    logic        key_event;
    logic [1:0]  state;

    modport master (
        output keyin, clr,
        input  an, seg, dp, digits, key_event, state
    );

    modport slave (
        input  keyin, clr,
        output an, seg, dp, digits, key_event, state
    );
endinterface

// File: rtl/key_entry_sseg.sv
// ---------------------------------------------------------------------------
// key_entry_sseg
//   Filters the keypad scanner's hex code, shifts accepted keys into a
//   4-digit entry register and time-multiplexes that register onto a 4-digit
//   common-anode seven-segment display.
//
//   Parameters
//     STABLE_CYCLES  cycles keyin must hold a new value before acceptance (>=2)
//     REFRESH_DIV    cycles each digit is lit before advancing (>=2)
//   Ports
//     clk   system clock
//     rst   synchronous, active-high reset
//     bus   key_entry_sseg_if.slave (keyin, clr in; an, seg, dp, digits,
//           key_event, state out)
// ---------------------------------------------------------------------------
module key_entry_sseg #(
    parameter int STABLE_CYCLES = 1000,
    parameter int REFRESH_DIV   = 100000
) (
    input  logic              clk,
    input  logic              rst,
    key_entry_sseg_if.slave   bus
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int RW = $clog2(REFRESH_DIV);
    // Compared against the pre-increment count so that the cycle in which
    // the count reaches STABLE_CYCLES-1 is also the cycle that enters COMMIT.
    localparam logic [SW-1:0] STAB_PRE = SW'(STABLE_CYCLES - 2);
    localparam logic [RW-1:0] CNT_LAST = RW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_QUAL   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    k_q;
    logic [3:0]    cand;
    logic [3:0]    accepted;
    logic [SW-1:0] stab_cnt;
    logic [15:0]   digits;
    logic [2:0]    count;
    logic          ovf;
    logic          key_event;
    logic [RW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        logic [6:0] g;
        case (h)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_WAIT;
            k_q       <= 4'h0;
            cand      <= 4'h0;
            accepted  <= 4'h0;
            stab_cnt  <= '0;
            digits    <= 16'h0000;
            count     <= 3'd0;
            ovf       <= 1'b0;
            key_event <= 1'b0;
            cnt       <= '0;
            idx       <= 2'd0;
            an        <= 4'b1111;
            seg       <= 7'b1111111;
            dp        <= 1'b1;
        end else begin
            k_q       <= bus.keyin;
            key_event <= 1'b0;

            case (state)
                S_WAIT: begin
                    if (k_q != accepted) begin
                        cand     <= k_q;
                        stab_cnt <= '0;
                        state    <= S_QUAL;
                    end
                end
                S_QUAL: begin
                    if (k_q != cand) begin
                        state <= S_WAIT;
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                        if (stab_cnt == STAB_PRE) begin
                            state <= S_COMMIT;
                        end
                    end
                end
                S_COMMIT: begin
                    accepted  <= cand;
                    digits    <= {digits[11:0], cand};
                    if (count == 3'd4) begin
                        ovf <= 1'b1;
                    end else begin
                        count <= count + 3'd1;
                    end
                    key_event <= 1'b1;
                    state     <= S_WAIT;
                end
                default: state <= S_WAIT;
            endcase

            // Clear overrides a coincident commit for the entry register
            // only; accepted still updates so a held key is not re-entered.
            if (bus.clr) begin
                digits <= 16'h0000;
                count  <= 3'd0;
                ovf    <= 1'b0;
                state  <= S_WAIT;
            end

            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Display drive is registered from the current idx, so it lags
            // idx by one cycle.
            an  <= ~(4'b0001 << idx);
            seg <= ({1'b0, idx} >= count) ? 7'b1111111
                                          : glyph(digits[{idx, 2'b00} +: 4]);
            dp  <= ~(ovf && (idx == 2'd0));
        end
    end

    assign bus.an        = an;
    assign bus.seg       = seg;
    assign bus.dp        = dp;
    assign bus.digits    = digits;
    assign bus.key_event = key_event;
    assign bus.state     = state;

endmodule

// File: tb/tb_key_entry_sseg.sv
module tb_key_entry_sseg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Each entry: {expected cycle of key_event [31:16], expected digits [15:0]}
    logic [31:0] exp_q[$];

    key_entry_sseg_if bus();

    key_entry_sseg #(
        .STABLE_CYCLES(4),
        .REFRESH_DIV(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference glyph table ----------------
    function automatic logic [6:0] ref_glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (bus.key_event === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_key_event actual digits=%h cyc=%0d required no event", bus.digits, cyc);
            end else begin
                logic [31:0] e;
                logic [31:0] a;
                e = exp_q.pop_front();
                a = {cyc[15:0], bus.digits};
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL key_event actual cyc/digits=%h required=%h", a, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_key(input logic [3:0] k, input logic [15:0] exp_digits);
        bus.keyin = k;
        exp_q.push_back({16'(cyc + 6), exp_digits});
        wait_cycles(10);
    endtask

    // Full refresh sweep: sync to the start of the an=1110 step, then check
    // five 8-cycle steps (digit 0,1,2,3,0) sample by sample.
    task automatic sweep(input logic [15:0] d, input int cnt_lit, input logic o);
        logic [3:0]  prev;
        int          guard;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [15:0] dd;
        prev  = bus.an;
        guard = 0;
        @(negedge clk);
        while (!(prev != 4'b1110 && bus.an == 4'b1110) && guard < 40) begin
            prev = bus.an;
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) begin
            n_checks++;
            n_fail++;
            $display("FAIL sweep_sync actual an=%b required 1110 within 40 cycles", bus.an);
        end else begin
            for (int step = 0; step < 5; step++) begin
                for (int s = 0; s < 8; s++) begin
                    int i;
                    i     = step % 4;
                    e_an  = ~(4'b0001 << i);
                    dd    = d >> (4 * i);
                    e_seg = (i < cnt_lit) ? ref_glyph(dd[3:0]) : 7'b1111111;
                    e_dp  = ~(o && (i == 0));
                    check("sweep_an_seg_dp", {20'h0, bus.an, bus.seg, bus.dp},
                          {20'h0, e_an, e_seg, e_dp});
                    @(negedge clk);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.keyin = 4'h0;
        bus.clr   = 1'b0;
        rst       = 1'b1;
        wait_cycles(2);
        check("reset_outputs", {16'h0, bus.an, bus.seg, bus.dp, bus.key_event, 2'b00, bus.state},
              {16'h0, 4'b1111, 7'b1111111, 1'b1, 1'b0, 2'b00, 2'd0});
        check("reset_digits", {16'h0, bus.digits}, 32'h0);
        rst = 1'b0;

        // 1. 0 -> 5, then refresh sweep with one lit digit
        press_key(4'h5, 16'h0005);
        check("t1_digits", {16'h0, bus.digits}, 32'h0005);
        sweep(16'h0005, 1, 1'b0);

        // 2. glitchy 5->7->5 with 2-cycle dwells: no commit
        bus.keyin = 4'h7;
        wait_cycles(2);
        bus.keyin = 4'h5;
        wait_cycles(12);
        check("t2_digits", {16'h0, bus.digits}, 32'h0005);

        // 3. keys 1,2,3,4,A -> overflow
        press_key(4'h1, 16'h0051);
        press_key(4'h2, 16'h0512);
        press_key(4'h3, 16'h5123);
        press_key(4'h4, 16'h1234);
        press_key(4'hA, 16'h234A);
        check("t3_digits", {16'h0, bus.digits}, 32'h234A);
        sweep(16'h234A, 4, 1'b1);

        // 5. clr coincident with COMMIT of key 9
        bus.keyin = 4'h9;
        exp_q.push_back({16'(cyc + 6), 16'h0000});
        wait_cycles(5);
        bus.clr = 1'b1;
        wait_cycles(1);
        bus.clr = 1'b0;
        wait_cycles(15);
        check("t5_digits", {16'h0, bus.digits}, 32'h0);
        check("t5_queue_drained", 32'(exp_q.size()), 32'h0);
        sweep(16'h0000, 0, 1'b0);

        // 6. reset in the middle of qualification
        bus.keyin = 4'h3;
        wait_cycles(3);
        check("t6_in_qual", {30'h0, bus.state}, 32'd1);
        rst       = 1'b1;
        bus.keyin = 4'h0;
        wait_cycles(1);
        check("t6_reset_outputs", {16'h0, bus.an, bus.seg, bus.dp, bus.key_event, 2'b00, bus.state},
              {16'h0, 4'b1111, 7'b1111111, 1'b1, 1'b0, 2'b00, 2'd0});
        check("t6_reset_digits", {16'h0, bus.digits}, 32'h0);
        rst = 1'b0;
        wait_cycles(15);
        check("t6_no_commit_digits", {16'h0, bus.digits}, 32'h0);

        check("final_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
